// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack memory port, and hands them to the core as ir.
// Optional build macro IFETCH_TIMEOUT_EN adds a WAIT-state watchdog that substitutes a NOP and sets a sticky fault.
module ifetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_req,
  input  logic              br_load,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  // state  | meaning
  // S_IDLE | no access outstanding; branches load pc directly, fetch_req launches a read
  // S_WAIT | read outstanding; req/addr held, branches parked as a pending redirect
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_addr;
  logic [ADDR_W-1:0] pc_next_ack;
  logic [ADDR_W-1:0] pc_next_abort;

  // A branch in the completing cycle beats anything parked earlier.
  always_comb begin
    pc_next_abort = pc;
    if (br_load)
      pc_next_abort = br_addr;
    else if (redir_pend)
      pc_next_abort = redir_addr;
    pc_next_ack = pc + ADDR_W'(1);
    if (br_load)
      pc_next_ack = br_addr;
    else if (redir_pend)
      pc_next_ack = redir_addr;
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      ir_valid   <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      redir_pend <= 1'b0;
      redir_addr <= '0;
`ifdef IFETCH_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      ir_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (br_load)
            pc <= br_addr;
          if (fetch_req) begin
            imem_addr <= br_load ? br_addr : pc;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_WAIT;
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            ir         <= imem_rdata;
            ir_valid   <= 1'b1;
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            redir_pend <= 1'b0;
            pc         <= pc_next_ack;
            state      <= S_IDLE;
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (wait_expired) begin
            // Abort with a NOP so the core keeps stepping; pc only moves on a redirect.
            ir         <= 32'h0;
            ir_valid   <= 1'b1;
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b1;
            redir_pend <= 1'b0;
            pc         <= pc_next_abort;
            state      <= S_IDLE;
          end
`endif
          else begin
            if (br_load) begin
              redir_pend <= 1'b1;
              redir_addr <= br_addr;
            end
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
